// File: rtl/clk_div_pkg.sv
// Shared constants, state encoding and divider clamp for the clk_div_ctrl block.
package clk_div_pkg;

  localparam int CNT_W_DEF   = 27;
  localparam int BURST_W_DEF = 16;
  localparam int DEF_DIV_DEF = 50000000;
  localparam int MIN_DIV     = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Periods below MIN_DIV would need a tick every cycle or none at all.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Control/config/status bundle for clk_div_ctrl; master drives start/stop/cfg, slave is the divider.
interface clk_div_ctrl_if
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
);
  logic               start;
  logic               stop;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_div;
  logic [BURST_W-1:0] cfg_burst;
  logic               tick;
  logic               sq_out;
  logic               running;
  logic               done;
  logic [CNT_W-1:0]   count;

  modport master (
    output start, stop, cfg_valid, cfg_div, cfg_burst,
    input  cfg_ready, tick, sq_out, running, done, count
  );

  modport slave (
    input  start, stop, cfg_valid, cfg_div, cfg_burst,
    output cfg_ready, tick, sq_out, running, done, count
  );
endinterface

// File: rtl/clk_div_sync2.sv
// Two-flop synchronizer for a single level signal, reset to 0.
module clk_div_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable generator: periodic tick, square wave, bursts, shadowed live reconfig.
// Optional CLKDIV_SYNC_START_EN: start/stop pass through 2-flop synchronizers first.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input logic          clk,
  input logic          rst,
  clk_div_ctrl_if.slave bus
);

  typedef struct packed {
    logic [CNT_W-1:0]   div;
    logic [BURST_W-1:0] burst;
  } cfg_t;

  state_t             state, state_nxt;
  logic               start_s, stop_s;
  logic [CNT_W-1:0]   cnt, div_act;
  logic [BURST_W-1:0] burst_act, ticks_left;
  cfg_t               shadow, cfg_in;
  logic               sh_vld, sq, done_r;
  logic               tick_c, cfg_ready_c, running_c;
  logic               cfg_fire, burst_end, go_run;

`ifdef CLKDIV_SYNC_START_EN
  clk_div_sync2 u_sync_start (.clk(clk), .rst(rst), .d(bus.start), .q(start_s));
  clk_div_sync2 u_sync_stop  (.clk(clk), .rst(rst), .d(bus.stop),  .q(stop_s));
`else
  assign start_s = bus.start;
  assign stop_s  = bus.stop;
`endif

  assign cfg_in.div   = CNT_W'(clamp_div(32'(bus.cfg_div)));
  assign cfg_in.burst = bus.cfg_burst;
  assign cfg_fire     = bus.cfg_valid & cfg_ready_c;

  // div_act only moves at a wrap, so cnt never exceeds div_act-1.
  assign tick_c    = (state == RUN) && (cnt == div_act - CNT_W'(1));
  assign burst_end = tick_c && (burst_act != '0) && (ticks_left == BURST_W'(1));
  assign go_run    = (state == IDLE) && start_s && !stop_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (go_run) state_nxt = RUN;
    end else begin
      if (stop_s || burst_end) state_nxt = IDLE;
    end
  end

  always_comb begin
    running_c   = (state == RUN);
    cfg_ready_c = (state == IDLE) || !sh_vld;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      div_act    <= CNT_W'(DEF_DIV);
      burst_act  <= '0;
      ticks_left <= '0;
      shadow     <= '0;
      sh_vld     <= 1'b0;
      sq         <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (tick_c) sq <= ~sq;
      if (state == IDLE) begin
        cnt <= '0;
        if (cfg_fire) begin
          div_act   <= cfg_in.div;
          burst_act <= cfg_in.burst;
        end
        if (go_run) ticks_left <= cfg_fire ? cfg_in.burst : burst_act;
      end else if (stop_s) begin
        // stop wins over a completing tick: no done, pending shadow dropped
        cnt    <= '0;
        sh_vld <= 1'b0;
      end else if (burst_end) begin
        cnt    <= '0;
        sh_vld <= 1'b0;
        done_r <= 1'b1;
      end else if (tick_c) begin
        cnt <= '0;
        if (cfg_fire) begin
          div_act    <= cfg_in.div;
          burst_act  <= cfg_in.burst;
          ticks_left <= cfg_in.burst;
        end else if (sh_vld) begin
          div_act    <= shadow.div;
          burst_act  <= shadow.burst;
          ticks_left <= shadow.burst;
          sh_vld     <= 1'b0;
        end else if (burst_act != '0) begin
          ticks_left <= ticks_left - BURST_W'(1);
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
        if (cfg_fire) begin
          shadow <= cfg_in;
          sh_vld <= 1'b1;
        end
      end
    end
  end

  assign bus.cfg_ready = cfg_ready_c;
  assign bus.tick      = tick_c;
  assign bus.sq_out    = sq;
  assign bus.running   = running_c;
  assign bus.done      = done_r;
  assign bus.count     = cnt;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl; k counts negedges after the edge that enters RUN.
module tb_clk_div_ctrl;

  localparam int CNT_W   = 27;
  localparam int BURST_W = 16;
  localparam int DEF_DIV = 6;
`ifdef CLKDIV_SYNC_START_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  clk_div_ctrl_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

  clk_div_ctrl #(.CNT_W(CNT_W), .BURST_W(BURST_W), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_idle(input int div, input int burst);
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = CNT_W'(div);
    bus.cfg_burst = BURST_W'(burst);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  // Returns at negedge k=1.
  task automatic begin_run();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (SL) @(negedge clk);
  endtask

  task automatic end_run();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    repeat (SL + 1) @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.cfg_valid = 1'b0;
    bus.cfg_div = '0; bus.cfg_burst = '0;
    repeat (2) @(negedge clk);
    chk("rst_running", 32'(bus.running), 0);
    chk("rst_tick", 32'(bus.tick), 0);
    chk("rst_sq", 32'(bus.sq_out), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_ready", 32'(bus.cfg_ready), 1);
    chk("rst_count", 32'(bus.count), 0);
    rst = 1'b0;
    @(negedge clk);

    // basic continuous run, div=5
    cfg_idle(5, 0);
    begin_run();
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("basic_tick_k%0d", k), 32'(bus.tick), 32'(k == 5 || k == 10 || k == 15));
      if (k == 1)  chk("basic_running", 32'(bus.running), 1);
      if (k == 3)  chk("basic_count", 32'(bus.count), 2);
      if (k == 3)  chk("basic_sq_k3", 32'(bus.sq_out), 0);
      if (k == 8)  chk("basic_sq_k8", 32'(bus.sq_out), 1);
      if (k == 13) chk("basic_sq_k13", 32'(bus.sq_out), 0);
      if (k == 16) chk("basic_sq_k16", 32'(bus.sq_out), 1);
    end
    end_run();
    chk("stop_running", 32'(bus.running), 0);
    chk("stop_count", 32'(bus.count), 0);
    chk("stop_sq_held", 32'(bus.sq_out), 1);

    // burst of 3 at div=4
    cfg_idle(4, 3);
    begin_run();
    for (int k = 1; k <= 18; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("burst_tick_k%0d", k), 32'(bus.tick), 32'(k == 4 || k == 8 || k == 12));
      chk($sformatf("burst_done_k%0d", k), 32'(bus.done), 32'(k == 13));
      chk($sformatf("burst_run_k%0d", k), 32'(bus.running), 32'(k <= 12));
    end
    @(negedge clk);

    // live reconfig: div 8 -> 3 offered mid-period
    cfg_idle(8, 0);
    begin_run();
    for (int k = 1; k <= 18; k++) begin
      if (k > 1) @(negedge clk);
      bus.cfg_valid = 1'b0;
      chk($sformatf("recfg_tick_k%0d", k), 32'(bus.tick), 32'(k == 8 || k == 11 || k == 14 || k == 17));
      if (k == 3) chk("recfg_ready_before", 32'(bus.cfg_ready), 1);
      if (k == 4) chk("recfg_ready_drop", 32'(bus.cfg_ready), 0);
      if (k == 8) chk("recfg_ready_at_tick", 32'(bus.cfg_ready), 0);
      if (k == 9) chk("recfg_ready_back", 32'(bus.cfg_ready), 1);
      if (k == 3) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = CNT_W'(3);
        bus.cfg_burst = '0;
      end
    end
    end_run();

    // clamp: cfg_div = 0 behaves as 2
    cfg_idle(0, 0);
    begin_run();
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("clamp_tick_k%0d", k), 32'(bus.tick), 32'(k % 2 == 0));
    end
    end_run();

    // start and stop together in IDLE stays IDLE
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    repeat (SL + 1) @(negedge clk);
    chk("startstop_idle", 32'(bus.running), 0);

    // stop coinciding with the completing tick of a burst
    cfg_idle(3, 2);
    begin_run();
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      bus.stop = 1'b0;
      if (k == 6) chk("stoptick_tick", 32'(bus.tick), 1);
      if (k >= 7) chk($sformatf("stoptick_done_k%0d", k), 32'(bus.done), 0);
      if (k >= 7) chk($sformatf("stoptick_run_k%0d", k), 32'(bus.running), 0);
      if (k == 6 - SL) bus.stop = 1'b1;
    end
    repeat (SL + 1) @(negedge clk);

    // start held through done restarts the burst
    cfg_idle(2, 1);
    bus.start = 1'b1;
    repeat (SL + 1) @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 2) chk("hold_tick", 32'(bus.tick), 1);
      if (k == 3) chk("hold_done", 32'(bus.done), 1);
      if (k == 3) chk("hold_idle", 32'(bus.running), 0);
      if (k == 4) chk("hold_restart", 32'(bus.running), 1);
    end
    bus.start = 1'b0;
    end_run();

    // async reset mid-run, then default period applies
    cfg_idle(4, 0);
    begin_run();
    repeat (5) @(negedge clk);
    chk("prerst_sq", 32'(bus.sq_out), 1);
    rst = 1'b1;
    #1;
    chk("midrst_running", 32'(bus.running), 0);
    chk("midrst_sq", 32'(bus.sq_out), 0);
    chk("midrst_count", 32'(bus.count), 0);
    chk("midrst_ready", 32'(bus.cfg_ready), 1);
    chk("midrst_tick", 32'(bus.tick), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    begin_run();
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("defdiv_tick_k%0d", k), 32'(bus.tick), 32'(k == 6));
    end
    end_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Programmable, synchronous clock-enable generator and controller for the board's clock-division path.
- Produces a single-cycle `tick` enable and a square-wave `sq_out` for LED/peripheral pacing from one clock domain. No ripple clocks.
- Supports start/stop sequencing, finite bursts of N ticks, and glitch-free reconfiguration through a valid/ready config port.

Parameters:
- CNT_W, 27, width of the period counter and `cfg_div`.
- BURST_W, 16, width of the burst tick counter.
- DEF_DIV, 50000000, period in clk cycles after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  level-sampled; begins ticking when in IDLE.
- stop  in  1  level-sampled; halts immediately.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config accept; transfer occurs when cfg_valid & cfg_ready.
- cfg_div  in  CNT_W  tick period in clk cycles; values 0 and 1 are clamped to 2.
- cfg_burst  in  BURST_W  number of ticks before auto-stop; 0 means continuous.
- tick  out  1  one-cycle enable, once per period.
- sq_out  out  1  toggles on every tick, giving clk/(2*div).
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse when a burst completes.
- count  out  CNT_W  current period counter, for debug.

Behaviour:
- Reset (async, rst=1) sets:
  - state = IDLE; cnt = 0; div_act = DEF_DIV; burst_act = 0; ticks_left = 0.
  - Shadow register empty; tick = sq_out = running = done = 0; cfg_ready = 1.
- FSM states: IDLE, RUN.
- IDLE:
  - cfg_ready = 1. An accepted config loads div_act/burst_act directly, with clamp.
  - start=1 & stop=0 → RUN next cycle, with cnt = 0 and ticks_left = burst_act.
- RUN:
  - cnt increments each cycle.
  - tick = 1 in the cycle where cnt == div_act-1; cnt then wraps to 0.
  - First tick occurs div_act cycles after the start-sampling edge. Thereafter the period is exactly div_act cycles.
- sq_out toggles at each tick edge and is held (not cleared) on stop.
- Burst (burst_act ≠ 0):
  - ticks_left decrements on each tick.
  - A tick with ticks_left == 1 → next cycle: state = IDLE, cnt = 0, done = 1 for one cycle.
- stop=1 in RUN → IDLE next cycle, cnt = 0, no done pulse. stop has priority over start and over a same-cycle tick-completion: the tick still pulses, but done does not.
- Config while RUN:
  - cfg_ready = 1 only when the shadow register is empty. An accepted config goes to the shadow and cfg_ready drops next cycle.
  - The shadow is applied at the next tick edge: div_act and burst_act update, ticks_left = new burst_act, shadow clears, cfg_ready returns to 1.
  - The new period starts from cnt = 0. No short or long period is ever emitted.
  - cfg accepted in the same cycle as a tick is applied at that tick.
- Leaving RUN via stop or done discards a pending shadow. It is not applied.
- div_act changes only at cnt wrap, so cnt < div_act always holds; no wrap-around past 2^CNT_W.
- start held high in IDLE after done restarts a burst on the next cycle.
- Reset mid-run returns everything to reset values immediately.

Optional Feature:
- Macro: CLKDIV_SYNC_START_EN.
- Defined: start and stop each pass through a 2-flop synchronizer (reset to 0) before the FSM, adding 2 cycles of latency to the start/stop response. This is intended for raw push-button inputs.
- Undefined: start/stop are sampled directly, with the timing described above.

Decomposition:
- Package clk_div_pkg:
  - state encoding (IDLE=0, RUN=1);
  - MIN_DIV = 2;
  - default CNT_W / BURST_W / DEF_DIV constants;
  - the clamp function (div < MIN_DIV → MIN_DIV).
- Sub-module clk_div_sync2: 2-flop synchronizer, instantiated twice, only under CLKDIV_SYNC_START_EN.

Test Plan:
- Reset values: assert rst mid-simulation → all outputs 0 and cfg_ready = 1 within the same cycle; count = 0.
- Basic run: IDLE config div=5, burst=0; pulse start → ticks at 5, 10, 15 cycles after the start edge; sq_out toggles with period 10; running = 1.
- Burst: div=4, burst=3, start → exactly 3 ticks, then done = 1 for one cycle one cycle after the third tick, running = 0; no further ticks.
- Live reconfig: running at div=8; offer div=3 mid-period → cfg_ready drops; current period completes at 8; the following ticks come every 3 cycles; cfg_ready returns high after that tick.
- Clamp/priority: cfg_div = 0 → period 2. start and stop asserted in the same cycle in IDLE → stays IDLE. stop on a tick-completion cycle of a burst → IDLE, no done pulse.
- With CLKDIV_SYNC_START_EN: start pulse → running rises 3 cycles after the sampling edge instead of 1.
